// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour solver: one-hot move codes, FSM states
// and the signed (dx,dy) offset of each move.
package tour_pkg;

    localparam logic [7:0] MV_M1P2 = 8'h01;
    localparam logic [7:0] MV_P1P2 = 8'h02;
    localparam logic [7:0] MV_M2P1 = 8'h04;
    localparam logic [7:0] MV_M2M1 = 8'h08;
    localparam logic [7:0] MV_M1M2 = 8'h10;
    localparam logic [7:0] MV_P1M2 = 8'h20;
    localparam logic [7:0] MV_P2M1 = 8'h40;
    localparam logic [7:0] MV_P2P1 = 8'h80;

    typedef enum logic [1:0] {StIdle, StInit, StTry, StBack} tour_state_t;

    function automatic logic signed [3:0] off_x(input logic [7:0] mv);
        logic signed [3:0] d;
        case (mv)
            MV_M1P2, MV_M1M2: d = -4'sd1;
            MV_P1P2, MV_P1M2: d = 4'sd1;
            MV_M2P1, MV_M2M1: d = -4'sd2;
            MV_P2M1, MV_P2P1: d = 4'sd2;
            default:          d = 4'sd0;
        endcase
        return d;
    endfunction

    function automatic logic signed [3:0] off_y(input logic [7:0] mv);
        logic signed [3:0] d;
        case (mv)
            MV_M1P2, MV_P1P2: d = 4'sd2;
            MV_M2P1, MV_P2P1: d = 4'sd1;
            MV_M2M1, MV_P2M1: d = -4'sd1;
            MV_M1M2, MV_P1M2: d = -4'sd2;
            default:          d = 4'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tour_move_stack.sv
// Move history of the solver: one one-hot move per tour step, written on push,
// with a pop-read port for backtracking and an async read port for replay.
module tour_move_stack
    import tour_pkg::*;
#(
    parameter int unsigned Depth = 24,
    parameter int unsigned IW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [IW-1:0] push_idx_i,
    input  logic [7:0]    push_mv_i,
    input  logic [IW-1:0] pop_idx_i,
    output logic [7:0]    pop_mv_o,
    input  logic [IW-1:0] rd_idx_i,
    output logic [7:0]    rd_mv_o
);

    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_i) begin
            mem_q[push_idx_i] <= push_mv_i;
        end
    end

    assign pop_mv_o = (pop_idx_i < IW'(Depth)) ? mem_q[pop_idx_i] : 8'h00;
    assign rd_mv_o  = (rd_idx_i < IW'(Depth)) ? mem_q[rd_idx_i] : 8'h00;

endmodule

// File: rtl/tour_solver_n.sv
// Backtracking knight's-tour solver for an N x N board, one candidate or pop per cycle.
// Define TOUR_CLOSED_EN to accept only closed tours.
module tour_solver_n
    import tour_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    x_start,
    input  logic [2:0]    y_start,
    input  logic          go,
    input  logic          abort,
    input  logic [IW-1:0] indx,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [7:0]    move
);

    localparam int unsigned   NSq     = N * N;
    localparam logic [IW-1:0] LastIdx = IW'(NSq - 2);
    localparam logic [IW-1:0] NIw     = IW'(N);
    localparam logic [3:0]    NU      = 4'(N);

    tour_state_t       state_q, state_d;
    logic signed [3:0] x_q, x_d, y_q, y_d;
    logic [IW-1:0]     move_num_q, move_num_d;
    logic [7:0]        try_q, try_d;
    logic [NSq-1:0]    visited_q, visited_d;
    logic              done_q, done_d, fail_q, fail_d;

    logic              push;
    logic [IW-1:0]     pop_idx;
    logic [7:0]        pop_mv;
    logic signed [3:0] nx, ny, px, py;
    logic [IW-1:0]     dst_sq, cur_sq, start_sq;
    logic              start_ok, in_board, closing_ok, cand_ok;

    function automatic logic [IW-1:0] sq_idx(input logic [2:0] x, input logic [2:0] y);
        return IW'(y) * NIw + IW'(x);
    endfunction

    // 4-bit signed positions: any step off the low or high edge reads as negative or >= N.
    assign nx       = x_q + off_x(try_q);
    assign ny       = y_q + off_y(try_q);
    assign in_board = !nx[3] && !ny[3] && ({1'b0, nx[2:0]} < NU) && ({1'b0, ny[2:0]} < NU);
    assign dst_sq   = sq_idx(nx[2:0], ny[2:0]);
    assign cur_sq   = sq_idx(x_q[2:0], y_q[2:0]);
    assign start_ok = ({1'b0, x_start} < NU) && ({1'b0, y_start} < NU);
    assign start_sq = sq_idx(x_start, y_start);
    assign pop_idx  = move_num_q - IW'(1);
    assign px       = x_q - off_x(pop_mv);
    assign py       = y_q - off_y(pop_mv);

`ifdef TOUR_CLOSED_EN
    logic signed [3:0] sx_q, sx_d, sy_q, sy_d, ddx, ddy, adx, ady;

    assign sx_d = (state_q == StInit) ? $signed({1'b0, x_start}) : sx_q;
    assign sy_d = (state_q == StInit) ? $signed({1'b0, y_start}) : sy_q;
    assign ddx  = nx - sx_q;
    assign ddy  = ny - sy_q;
    assign adx  = ddx[3] ? -ddx : ddx;
    assign ady  = ddy[3] ? -ddy : ddy;
    // The last square must be a knight's move away from the start.
    assign closing_ok = (move_num_q != LastIdx) ||
                        (adx == 4'sd1 && ady == 4'sd2) || (adx == 4'sd2 && ady == 4'sd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q <= 4'sd0;
            sy_q <= 4'sd0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end
`else
    assign closing_ok = 1'b1;
`endif

    assign cand_ok = in_board && !visited_q[dst_sq] && closing_ok;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        move_num_d = move_num_q;
        try_d      = try_q;
        visited_d  = visited_q;
        done_d     = done_q;
        fail_d     = fail_q;
        push       = 1'b0;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        state_d = StInit;
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                    end
                end
                StInit: begin
                    if (!start_ok) begin
                        fail_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        visited_d           = '0;
                        visited_d[start_sq] = 1'b1;
                        x_d                 = $signed({1'b0, x_start});
                        y_d                 = $signed({1'b0, y_start});
                        move_num_d          = '0;
                        try_d               = MV_M1P2;
                        state_d             = StTry;
                    end
                end
                StTry: begin
                    if (cand_ok) begin
                        push              = 1'b1;
                        x_d               = nx;
                        y_d               = ny;
                        visited_d[dst_sq] = 1'b1;
                        move_num_d        = move_num_q + IW'(1);
                        try_d             = MV_M1P2;
                        if (move_num_q == LastIdx) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else if (try_q != MV_P2P1) begin
                        try_d = try_q << 1;
                    end else begin
                        state_d = StBack;
                    end
                end
                StBack: begin
                    if (move_num_q == '0) begin
                        fail_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        visited_d[cur_sq] = 1'b0;
                        x_d               = px;
                        y_d               = py;
                        move_num_d        = pop_idx;
                        // A popped bit7 has no successor candidate: keep unwinding.
                        if (pop_mv != MV_P2P1) begin
                            try_d   = pop_mv << 1;
                            state_d = StTry;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x_q        <= 4'sd0;
            y_q        <= 4'sd0;
            move_num_q <= '0;
            try_q      <= MV_M1P2;
            visited_q  <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            move_num_q <= move_num_d;
            try_q      <= try_d;
            visited_q  <= visited_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    tour_move_stack #(
        .Depth(NSq - 1),
        .IW   (IW)
    ) u_stack (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .push_i    (push),
        .push_idx_i(move_num_q),
        .push_mv_i (try_q),
        .pop_idx_i (pop_idx),
        .pop_mv_o  (pop_mv),
        .rd_idx_i  (indx),
        .rd_mv_o   (move)
    );

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign fail = fail_q;

endmodule
